// File: rtl/pong_game_sequencer_if.sv
// Pong game-flow bus: frame/button/ball events into the sequencer, control and
// scoreboard values back to the game and display.
//   master: game module / display side (drives events, reads control)
//   slave : pong_game_sequencer
interface pong_game_sequencer_if;
  logic        frame_tick;  // one-cycle pulse at end of frame
  logic        start_btn;   // raw start button, asynchronous
  logic        pause_btn;   // raw pause button, asynchronous
  logic        ball_hit;    // one-cycle pulse, paddle bounce
  logic        ball_miss;   // one-cycle pulse, bottom wall touched
  logic        serve;       // one-cycle pulse, recentre ball
  logic        ball_run;    // ball moves only while high
  logic [2:0]  ball_speed;  // pixels per frame step
  logic [15:0] score;       // four BCD digits, [3:0] = units
  logic [2:0]  lives;       // remaining lives
  logic        flash;       // miss-screen indicator
  logic [2:0]  state;       // IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4 PAUSE=5

  modport master (
    output frame_tick, start_btn, pause_btn, ball_hit, ball_miss,
    input  serve, ball_run, ball_speed, score, lives, flash, state
  );

  modport slave (
    input  frame_tick, start_btn, pause_btn, ball_hit, ball_miss,
    output serve, ball_run, ball_speed, score, lives, flash, state
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: sequences attract/serve/play/miss/over phases,
// keeps BCD score, lives and speed level, and gates ball motion. All phase
// timing is counted in video frames.
// Ports:
//   clk25 - 25 MHz pixel clock
//   Reset - asynchronous reset, active high
//   bus   - pong_game_sequencer_if.slave (events in, control/score out)
// Optional feature macro: PONG_PAUSE_EN (pause button toggles PLAY <-> PAUSE).
module pong_game_sequencer #(
  parameter int unsigned LIVES          = 3,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned MISS_FRAMES    = 63,
  parameter int unsigned HITS_PER_LEVEL = 5,
  parameter int unsigned MAX_SPEED      = 4
) (
  input logic                  clk25,
  input logic                  Reset,
  pong_game_sequencer_if.slave bus
);

  localparam int unsigned FRAME_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int unsigned FW        = $clog2(FRAME_MAX + 1);
  localparam int unsigned HW        = $clog2(HITS_PER_LEVEL + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   score_q, score_d;
  logic [2:0]    lives_q, lives_d;
  logic [2:0]    speed_q, speed_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          serve_q, serve_d;
  logic          run_q, run_d;
  logic          flash_q, flash_d;

  logic start_s1_q, start_s2_q, start_s3_q, start_rise_q;
  logic pause_rise;

  // Saturating four-digit BCD increment with per-digit carry
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

`ifdef PONG_PAUSE_EN
  logic pause_s1_q, pause_s2_q, pause_s3_q, pause_rise_q;

  // Pause button synchroniser and registered rising-edge detect
  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      pause_s1_q   <= 1'b0;
      pause_s2_q   <= 1'b0;
      pause_s3_q   <= 1'b0;
      pause_rise_q <= 1'b0;
    end else begin
      pause_s1_q   <= bus.pause_btn;
      pause_s2_q   <= pause_s1_q;
      pause_s3_q   <= pause_s2_q;
      pause_rise_q <= pause_s2_q & ~pause_s3_q;
    end
  end

  assign pause_rise = pause_rise_q;
`else
  assign pause_rise = 1'b0;
`endif

  // Next-state, scoreboard and output decode
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    speed_d     = speed_q;
    hit_cnt_d   = hit_cnt_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise_q) begin
          score_d   = 16'h0000;
          lives_d   = 3'(LIVES);
          speed_d   = 3'd1;
          hit_cnt_d = '0;
          state_d   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_cnt_q == FW'(SERVE_FRAMES)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A coincident miss swallows the hit
        if (bus.ball_miss) begin
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          state_d = ST_MISS;
        end else begin
          if (bus.ball_hit) begin
            score_d = bcd_inc(score_q);
            if (hit_cnt_q == HW'(HITS_PER_LEVEL - 1)) begin
              hit_cnt_d = '0;
              speed_d   = (speed_q >= 3'(MAX_SPEED)) ? 3'(MAX_SPEED) : speed_q + 3'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + HW'(1);
            end
          end
          if (pause_rise) state_d = ST_PAUSE;
        end
      end
      ST_MISS: begin
        if (frame_cnt_q == FW'(MISS_FRAMES)) state_d = (lives_q == 3'd0) ? ST_OVER : ST_SERVE;
      end
      ST_PAUSE: begin
        if (pause_rise) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame counter restarts on entry; an entry-cycle tick belongs to the new state
    if (state_d != state_q) begin
      frame_cnt_d = bus.frame_tick ? FW'(1) : '0;
    end else if (bus.frame_tick && (frame_cnt_q != FW'(FRAME_MAX))) begin
      frame_cnt_d = frame_cnt_q + FW'(1);
    end

    serve_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    run_d   = (state_d == ST_PLAY);
    flash_d = (state_d == ST_MISS);
  end

  // Registers: start synchroniser, FSM state, scoreboard and outputs
  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_s3_q   <= 1'b0;
      start_rise_q <= 1'b0;
      state_q      <= ST_IDLE;
      score_q      <= 16'h0000;
      lives_q      <= 3'(LIVES);
      speed_q      <= 3'd1;
      hit_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      serve_q      <= 1'b0;
      run_q        <= 1'b0;
      flash_q      <= 1'b0;
    end else begin
      start_s1_q   <= bus.start_btn;
      start_s2_q   <= start_s1_q;
      start_s3_q   <= start_s2_q;
      start_rise_q <= start_s2_q & ~start_s3_q;
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      speed_q      <= speed_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      serve_q      <= serve_d;
      run_q        <= run_d;
      flash_q      <= flash_d;
    end
  end

  assign bus.serve      = serve_q;
  assign bus.ball_run   = run_q;
  assign bus.ball_speed = speed_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.flash      = flash_q;
  assign bus.state      = state_q;

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Game-flow controller for the Pong datapath; sits beside the ball/paddle game module on the 25 MHz pixel clock.
Sequences attract, serve, play, miss and game-over phases, and gates ball motion.
Keeps BCD score, lives and speed level, and issues the serve strobe that recentres the ball.
All timing is counted in video frames via the end-of-frame tick.

Parameters:
LIVES, 3, lives loaded at game start (1..7)
SERVE_FRAMES, 60, frames ball is held at centre before play
MISS_FRAMES, 63, frames of miss flash after a miss
HITS_PER_LEVEL, 5, paddle hits per speed increment
MAX_SPEED, 4, ball_speed saturation value (1..7)

Ports:
clk25  input  1  pixel clock
Reset  input  1  asynchronous reset, active high
frame_tick  input  1  one-cycle pulse at end of frame (xpos==0, ypos==480)
start_btn  input  1  raw start button, asynchronous
pause_btn  input  1  raw pause button, asynchronous; used only with PONG_PAUSE_EN
ball_hit  input  1  one-cycle pulse, ball bounced off paddle
ball_miss  input  1  one-cycle pulse, ball touched bottom wall
serve  output  1  one-cycle pulse; game module reloads ball to centre
ball_run  output  1  ball position updates only while high
ball_speed  output  3  pixels moved per frame step
score  output  16  four BCD digits, score[3:0] = units
lives  output  3  remaining lives
flash  output  1  miss-screen indicator
state  output  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, PAUSE=5

Behaviour:
- Reset (async, any time, including mid-game) forces:
  - state=IDLE, score=0, lives=LIVES, ball_speed=1
  - serve=0, ball_run=0, flash=0
  - frame and hit counters cleared, synchroniser flops cleared
- Button inputs:
  - 2-flop synchroniser, then rising-edge register.
  - start_rise is high one cycle, 3 clk25 edges after the button rises.
- All outputs are registered. ball_run=1 only in PLAY; flash=1 only in MISS.
- A frame counter clears on every state entry and increments on each frame_tick.
- IDLE:
  - On start_rise: load score=0, lives=LIVES, ball_speed=1, hit_cnt=0.
  - Then go to SERVE.
- Entry to SERVE, from any state: serve=1 in the same cycle the state register becomes SERVE, for exactly one cycle.
- SERVE: when the frame counter reaches SERVE_FRAMES, go to PLAY.
- PLAY, on ball_hit:
  - score += 1 in BCD with per-digit carry; saturates at 9999.
  - hit_cnt += 1.
  - When hit_cnt reaches HITS_PER_LEVEL: hit_cnt=0 and ball_speed += 1, saturating at MAX_SPEED.
- PLAY, on ball_miss: lives -= 1 (never below 0), then go to MISS.
- PLAY, ball_hit and ball_miss in the same cycle: the miss wins and the hit is discarded.
- MISS: when the frame counter reaches MISS_FRAMES:
  - lives==0: go to OVER.
  - otherwise: go to SERVE (with serve pulse).
  - ball_speed and hit_cnt are retained.
- OVER: score is held for display. start_rise performs the IDLE load and goes directly to SERVE.
- ball_hit and ball_miss are ignored outside PLAY. start_rise is ignored outside IDLE and OVER.
- A frame_tick coincident with a state transition counts toward the new state's counter, not the old one.

Optional Feature:
PONG_PAUSE_EN
- Defined:
  - pause_btn is synchronised and edge-detected like start_btn.
  - pause_rise in PLAY: go to PAUSE, with ball_run=0.
  - pause_rise in PAUSE: return to PLAY.
  - In PAUSE, ball_hit, ball_miss and start are ignored; score, lives, speed and hit_cnt are frozen.
- Not defined: pause_btn is ignored, state value 5 is unreachable, and the port remains for a fixed interface.

Test Plan:
Bench parameters for all scenarios: LIVES=2, SERVE_FRAMES=3, MISS_FRAMES=2, HITS_PER_LEVEL=2, MAX_SPEED=3; frame_tick every 10 clocks.
1. Reset release, raise start_btn -> state=SERVE 4 clocks after the rise; serve high exactly 1 cycle; PLAY after 3 frame_ticks; ball_run=1.
2. In PLAY, 5 ball_hit pulses -> score=0x0005; ball_speed 1->2 after hit 2, ->3 after hit 4, stays 3 after hit 5.
3. Preload score to 0x0999, 1 hit -> score=0x1000; at 0x9999, 1 hit -> stays 0x9999.
4. ball_miss and ball_hit in the same cycle in PLAY -> lives 2->1, score unchanged, state=MISS, flash=1; after 2 frame_ticks -> SERVE with serve pulse.
5. Second miss -> lives=0, MISS, then OVER; score held; start_rise -> score=0, lives=2, state=SERVE.
6. Assert Reset mid-MISS, between clock edges -> outputs immediately at reset values, state=IDLE. With PONG_PAUSE_EN: pause in PLAY -> ball_run=0 and ball_hit ignored; second pause -> PLAY.
